// File: rtl/wbuf_pkg.sv
// -----------------------------------------------------------------------------
// wbuf_pkg
// Shared types and constants for the store write buffer.
//   - wbuf_state_t : drain FSM encoding (IDLE, SEND, RESP)
//   - OKAY, SLVERR : AXI write response codes
//   - wbuf_entry_t : one buffered store {addr, data}
// The entry struct is sized by WBUF_ADDR_W / WBUF_DATA_W; the ADDR_W and
// DATA_W parameters of the buffer default to these and must stay equal to them.
// -----------------------------------------------------------------------------
package wbuf_pkg;

    localparam int WBUF_ADDR_W = 32;
    localparam int WBUF_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        RESP = 2'd2
    } wbuf_state_t;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

    typedef struct packed {
        logic [WBUF_ADDR_W-1:0] addr;
        logic [WBUF_DATA_W-1:0] data;
    } wbuf_entry_t;

endpackage

// File: rtl/wbuf_fifo.sv
// -----------------------------------------------------------------------------
// wbuf_fifo
// DEPTH-entry in-order store queue with a per-entry address comparator.
//   clk, reset   : clock, asynchronous active-high reset
//   push         : request to enqueue push_entry (ignored while full)
//   push_entry   : entry to enqueue
//   pop          : dequeue the head (caller guarantees the FIFO is not empty)
//   rd_word      : load word address (byte address without the two LSBs)
//   head         : oldest entry
//   full, empty  : occupancy flags derived from the registered count
//   hit_vec      : per-slot match of rd_word against valid entries only
// -----------------------------------------------------------------------------
module wbuf_fifo
    import wbuf_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = WBUF_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  wbuf_entry_t       push_entry,
    input  logic              pop,
    input  logic [ADDR_W-3:0] rd_word,
    output wbuf_entry_t       head,
    output logic              full,
    output logic              empty,
    output logic [DEPTH-1:0]  hit_vec
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    wbuf_entry_t      mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;

    // A store offered while full is refused even if the head pops this cycle.
    assign do_push = push && !full;
    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign head    = mem[rd_ptr];

    // NOTE: storage is not reset; a slot's contents only matter while it is
    // inside the valid window, so clearing it would buy nothing.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_entry;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Slot i is valid when its distance from the head (modulo DEPTH) is below
    // count; stale data in free slots must never raise a hazard.
    for (genvar i = 0; i < DEPTH; i++) begin : g_cmp
        logic [PTR_W-1:0] offs;
        logic             valid;
        assign offs       = PTR_W'(i) - rd_ptr;
        assign valid      = ({1'b0, offs} < count);
        assign hit_vec[i] = valid && (mem[i].addr[ADDR_W-1:2] == rd_word);
    end

endmodule

// File: rtl/store_write_buffer.sv
// -----------------------------------------------------------------------------
// store_write_buffer
// Posted-write buffer between the core data-memory port and an AXI4-Lite
// write channel. Core stores are queued and drained in order, one single-beat
// AXI write at a time.
//   clk, reset        : clock, asynchronous active-high reset
//   memwrite          : core store strobe
//   aluout, writedata : store byte address / data
//   rd_addr           : core load address for the read-after-write check
//   stall             : buffer full, core must hold its store
//   empty             : nothing queued and no AXI write in flight
//   raw_hit           : rd_addr word matches a queued (or in-flight) store
//   aw*/w*/b*         : AXI4-Lite write address, data and response channels
//   err               : sticky, set by any non-OKAY write response
// -----------------------------------------------------------------------------
module store_write_buffer
    import wbuf_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = WBUF_ADDR_W,
    parameter int DATA_W = WBUF_DATA_W
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                memwrite,
    input  logic [ADDR_W-1:0]   aluout,
    input  logic [DATA_W-1:0]   writedata,
    input  logic [ADDR_W-1:0]   rd_addr,
    output logic                stall,
    output logic                empty,
    output logic                raw_hit,
    output logic [ADDR_W-1:0]   awaddr,
    output logic                awvalid,
    input  logic                awready,
    output logic [DATA_W-1:0]   wdata,
    output logic [DATA_W/8-1:0] wstrb,
    output logic                wvalid,
    input  logic                wready,
    input  logic [1:0]          bresp,
    input  logic                bvalid,
    output logic                bready,
    output logic                err
);

    wbuf_state_t       state, state_n;
    logic              awvalid_n, wvalid_n, bready_n, err_n;
    logic [ADDR_W-1:0] awaddr_n;
    logic [DATA_W-1:0] wdata_n;

    wbuf_entry_t       push_entry;
    wbuf_entry_t       head;
    logic              fifo_full;
    logic              fifo_empty;
    logic              pop;
    logic [DEPTH-1:0]  hit_vec;

    // Byte-lane bits are irrelevant: stores are word-aligned and hazards are
    // checked per word.
    logic unused_byte_bits;
    assign unused_byte_bits = ^{aluout[1:0], rd_addr[1:0]};

    assign push_entry.addr = {aluout[ADDR_W-1:2], 2'b00};
    assign push_entry.data = writedata;

    wbuf_fifo #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .push       (memwrite),
        .push_entry (push_entry),
        .pop        (pop),
        .rd_word    (rd_addr[ADDR_W-1:2]),
        .head       (head),
        .full       (fifo_full),
        .empty      (fifo_empty),
        .hit_vec    (hit_vec)
    );

    assign stall   = fifo_full;
    assign empty   = fifo_empty && (state == IDLE);
    assign raw_hit = |hit_vec;
    assign wstrb   = '1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            awvalid <= 1'b0;
            wvalid  <= 1'b0;
            bready  <= 1'b0;
            err     <= 1'b0;
            awaddr  <= '0;
            wdata   <= '0;
        end else begin
            state   <= state_n;
            awvalid <= awvalid_n;
            wvalid  <= wvalid_n;
            bready  <= bready_n;
            err     <= err_n;
            awaddr  <= awaddr_n;
            wdata   <= wdata_n;
        end
    end

    // NOTE: every output of this block is given its hold value first, so no
    // path through the case leaves a signal unassigned and no latch appears.
    always_comb begin
        state_n   = state;
        awvalid_n = awvalid;
        wvalid_n  = wvalid;
        bready_n  = bready;
        err_n     = err;
        awaddr_n  = awaddr;
        wdata_n   = wdata;
        pop       = 1'b0;

        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    awaddr_n  = head.addr;
                    wdata_n   = head.data;
                    awvalid_n = 1'b1;
                    wvalid_n  = 1'b1;
                    state_n   = SEND;
                end
            end
            SEND: begin
                // AW and W complete independently; move on once both are done.
                if (awvalid && awready) begin
                    awvalid_n = 1'b0;
                end
                if (wvalid && wready) begin
                    wvalid_n = 1'b0;
                end
                if (!awvalid_n && !wvalid_n) begin
                    bready_n = 1'b1;
                    state_n  = RESP;
                end
            end
            RESP: begin
                // The head leaves the queue only now, so raw_hit covers it
                // for the whole transaction, whatever the response.
                if (bvalid && bready) begin
                    pop      = 1'b1;
                    bready_n = 1'b0;
                    state_n  = IDLE;
                    if (bresp != OKAY) begin
                        err_n = 1'b1;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: doc/store_write_buffer.md
Name: store_write_buffer

Overview:
- Posted-write buffer between the MIPS core's data-memory port and the AXI write channel.
- Captures each core store (`aluout` as address, `writedata` as data, strobed by `memwrite`) into a DEPTH-entry FIFO.
- Drains entries in order as single-beat AXI4-Lite writes (AW/W/B).
- Back-pressures the core with `stall` when the FIFO is full. Flags read-after-write hazards against pending entries.

Parameters:
- DEPTH, 4, FIFO entries; power of two, at least 2.
- ADDR_W, 32, address width.
- DATA_W, 32, data width; WSTRB width = DATA_W/8.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- memwrite  in  1  core store strobe.
- aluout  in  ADDR_W  store byte address.
- writedata  in  DATA_W  store data.
- rd_addr  in  ADDR_W  core load address, for hazard check.
- stall  out  1  buffer full; core must hold the store.
- empty  out  1  no pending stores and no AXI write outstanding.
- raw_hit  out  1  rd_addr word matches a pending entry.
- awaddr  out  ADDR_W  AXI write address.
- awvalid  out  1  AXI address valid.
- awready  in  1  AXI address ready.
- wdata  out  DATA_W  AXI write data.
- wstrb  out  DATA_W/8  AXI write strobes; always all-ones.
- wvalid  out  1  AXI data valid.
- wready  in  1  AXI data ready.
- bresp  in  2  AXI write response.
- bvalid  in  1  AXI response valid.
- bready  out  1  AXI response ready.
- err  out  1  sticky error: a non-OKAY response was received.

Behaviour:
- Reset (async, active-high) values:
  - awvalid, wvalid, bready, err = 0.
  - stall = 0, empty = 1, raw_hit = 0.
  - FIFO pointers and count = 0; FSM = IDLE.
  - Reset mid-transaction abandons all pending entries and the outstanding transaction.
- FIFO:
  - Push on a rising clk when memwrite && !stall. Entry = {aluout[ADDR_W-1:2], 2'b00}, writedata.
  - stall = (count == DEPTH), registered from count.
  - A store presented while full is not accepted, even if a pop occurs in the same cycle. The core re-presents it next cycle.
  - Pointers are log2(DEPTH) bits and wrap naturally. count is log2(DEPTH)+1 bits.
  - Simultaneous push and pop when not full: count unchanged, both pointers advance.
- Drain FSM, states IDLE, SEND, RESP:
  - IDLE: if count != 0, load awaddr/wdata from the head entry, set awvalid = wvalid = 1, go to SEND.
  - First awvalid appears one cycle after the push edge into an empty FIFO.
  - SEND: awvalid drops on the cycle after awready is sampled high; wvalid likewise with wready. The two may be accepted in either order or the same cycle.
  - SEND → RESP once both have been accepted; bready = 1 on entering RESP.
  - awaddr/wdata stay stable while their valid is high.
  - RESP: on bvalid && bready, pop the head, set bready = 0, go to IDLE. If bresp != 2'b00, set err = 1.
  - err is sticky; it clears only on reset. The entry is popped regardless of response.
  - At most one outstanding transaction. Minimum per-store throughput is 3 cycles (IDLE, SEND, RESP).
- empty = (count == 0) && FSM == IDLE. The head entry is not popped until its response is received.
- raw_hit is combinational: rd_addr[ADDR_W-1:2] equals the address of any valid entry, including the in-flight head. Invalid slots never match.

Decomposition:
- Shared package `wbuf_pkg`:
  - FSM state encoding: IDLE=2'd0, SEND=2'd1, RESP=2'd2.
  - AXI response constants: OKAY=2'b00, SLVERR=2'b10.
  - Entry struct {addr, data}.
- One sub-module `wbuf_fifo`: storage, pointers, count, full/empty, and the per-entry address compare vector for raw_hit.
- The FSM and AXI outputs live in `store_write_buffer`.

Test Plan:
- Single store: memwrite=1, aluout=0x54, writedata=21 for one cycle; awready=wready=1, bvalid one cycle after acceptance → awaddr=0x54, wdata=21, wstrb=4'hF; one AW and one W handshake; empty returns to 1; err=0.
- Fill/stall: DEPTH=4, awready held 0, push 5 stores 0x100..0x110 data 1..5 → stall=1 after the 4th push; the 5th is not accepted until the first B completes. All 5 drain in address order.
- Split handshake: wready high two cycles before awready → wvalid drops first, awvalid holds 0x200 until accepted; bready asserts only after both are accepted.
- Error response: bresp=2'b10 on the first store to 0x300 → err=1 and stays 1 through subsequent OKAY writes; the entry is still popped.
- RAW hazard: pending store to 0x404 (awready=0), rd_addr=0x406 → raw_hit=1. rd_addr=0x408 → raw_hit=0. After the B response, rd_addr=0x404 → raw_hit=0.
- Reset mid-operation: assert reset during SEND with 3 entries pending → awvalid=wvalid=bready=0 immediately (async), empty=1, stall=0. The next store after release drains normally.
